// File: rtl/text_console_writer_pkg.sv
// console_pkg: shared constants for the text console writer.
//   - Screen geometry (COLS x ROWS glyphs, 4 glyphs packed per 32-bit word).
//   - VRAM word count and the address of the colour control register
//     that sits directly after the text area and must never be written.
//   - ASCII control codes recognised by the writer.
//   - FSM state encoding and a printable-glyph classifier.
package console_pkg;

  localparam int COLS          = 80;
  localparam int ROWS          = 30;
  localparam int WORDS_PER_ROW = COLS / 4;
  localparam int VRAM_WORDS    = ROWS * WORDS_PER_ROW;
  localparam int CTRL_REG_ADDR = VRAM_WORDS;

  localparam logic [6:0] ASCII_LF = 7'h0A;
  localparam logic [6:0] ASCII_CR = 7'h0D;
  localparam logic [6:0] ASCII_BS = 7'h08;
  localparam logic [6:0] ASCII_FF = 7'h0C;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PUT    = 3'd1,
    ST_SCROLL = 3'd2,
    ST_FILL   = 3'd3,
    ST_CLEAR  = 3'd4
  } state_e;

  // Glyph codes 0x20..0x7E are drawn; everything else is control or ignored.
  function automatic logic is_printable(input logic [6:0] code);
    return (code >= 7'h20) && (code <= 7'h7E);
  endfunction

endpackage

// File: rtl/text_console_writer_if.sv
// text_console_writer_if: glyph stream handshake plus the VRAM port.
//   char_valid/char_data/char_ready : glyph stream into the writer
//   vram_re/vram_raddr/vram_rdata   : VRAM read port (data 1 cycle after re)
//   vram_we/vram_waddr/vram_wdata/vram_be : VRAM write port, byte enables
// master = the writer, slave = the producer / VRAM side.
interface text_console_writer_if;

  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;

  logic        vram_re;
  logic [9:0]  vram_raddr;
  logic [31:0] vram_rdata;
  logic        vram_we;
  logic [9:0]  vram_waddr;
  logic [31:0] vram_wdata;
  logic [3:0]  vram_be;

  modport master (
    input  char_valid, char_data, vram_rdata,
    output char_ready, vram_re, vram_raddr, vram_we, vram_waddr, vram_wdata, vram_be
  );

  modport slave (
    output char_valid, char_data, vram_rdata,
    input  char_ready, vram_re, vram_raddr, vram_we, vram_waddr, vram_wdata, vram_be
  );

endinterface

// File: rtl/text_console_writer_cursor.sv
// console_cursor: cursor position registers for the text console writer.
//   clk, srst        : clock, synchronous active-high reset (cursor -> 0,0)
//   col_advance      : step right, wrapping to the next row after the last column
//   row_advance      : step down one row
//   carriage_return  : column -> 0 (combined with row_advance for LF)
//   back_space       : column - 1 unless already at column 0
//   home             : cursor -> 0,0
//   x, y             : current column / row
//   wrap_bottom      : a row step is requested while on the last row; the row
//                      stays put and the caller is expected to scroll
module console_cursor
#(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       col_advance,
  input  logic       row_advance,
  input  logic       carriage_return,
  input  logic       back_space,
  input  logic       home,
  output logic [6:0] x,
  output logic [4:0] y,
  output logic       wrap_bottom
);
  import console_pkg::*;

  logic [6:0] x_reg;
  logic [4:0] y_reg;
  logic       col_wrap;
  logic       row_step;
  logic       last_row;

  assign col_wrap    = col_advance && (x_reg == 7'(COLS - 1));
  assign row_step    = row_advance || col_wrap;
  assign last_row    = (y_reg == 5'(ROWS - 1));
  assign wrap_bottom = row_step && last_row;

  always_ff @(posedge clk) begin
    if (srst || home) begin
      x_reg <= 7'd0;
      y_reg <= 5'd0;
    end else begin
      if (carriage_return || col_wrap)
        x_reg <= 7'd0;
      else if (col_advance)
        x_reg <= x_reg + 7'd1;
      else if (back_space && (x_reg != 7'd0))
        x_reg <= x_reg - 7'd1;

      // On the last row the row index holds; the scroll moves the text instead.
      if (row_step && !last_row)
        y_reg <= y_reg + 5'd1;
    end
  end

  assign x = x_reg;
  assign y = y_reg;

endmodule

// File: rtl/text_console_writer.sv
// text_console_writer: turns a stream of 8-bit glyph codes into writes to the
// packed text VRAM (4 glyphs per 32-bit word, COLS/4 words per row).
//   Clk, Reset  : clock, synchronous active-high reset
//   bus         : glyph handshake + VRAM read/write port (master side)
//   cursor_x/y  : current cursor column / row
//   busy        : high whenever the FSM is not idle
// Printable glyphs take one PUT cycle; LF/CR/BS/other codes are handled in
// the accept cycle; FF clears the screen; a row step past the bottom copies
// every row up by one (SCROLL) and blanks the last row (FILL).
module text_console_writer
#(
  parameter int         COLS           = console_pkg::COLS,
  parameter int         ROWS           = console_pkg::ROWS,
  parameter logic [7:0] BLANK          = 8'h20,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic                        Clk,
  input  logic                        Reset,
  text_console_writer_if.master       bus,
  output logic [6:0]                  cursor_x,
  output logic [4:0]                  cursor_y,
  output logic                        busy
);
  import console_pkg::*;

  localparam int WPR          = COLS / 4;
  localparam int WORDS        = ROWS * WPR;
  localparam int SCROLL_WORDS = WORDS - WPR;

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_PUT    = ST_PUT;
  localparam logic [2:0] S_SCROLL = ST_SCROLL;
  localparam logic [2:0] S_FILL   = ST_FILL;
  localparam logic [2:0] S_CLEAR  = ST_CLEAR;

  logic [2:0]  state_reg, state_next;
  logic [9:0]  k_reg, k_next;
  logic [7:0]  glyph_reg;
  logic        accept;
  logic [6:0]  code;
  logic        col_advance, row_advance, carriage_return, back_space, home;
  logic        wrap_bottom;
  logic [9:0]  put_addr;
  logic [3:0]  put_be;
  logic [31:0] put_data;

  assign code           = bus.char_data[6:0];
  assign bus.char_ready = (state_reg == S_IDLE) && !Reset;
  assign accept         = bus.char_valid && bus.char_ready;
  assign busy           = (state_reg != S_IDLE) && !Reset;

  console_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .clk             (Clk),
    .srst            (Reset),
    .col_advance     (col_advance),
    .row_advance     (row_advance),
    .carriage_return (carriage_return),
    .back_space      (back_space),
    .home            (home),
    .x               (cursor_x),
    .y               (cursor_y),
    .wrap_bottom     (wrap_bottom)
  );

  // Cursor commands. Kept apart from the next-state logic because the
  // latter depends on wrap_bottom, which is derived from these commands.
  always_comb begin
    col_advance     = 1'b0;
    row_advance     = 1'b0;
    carriage_return = 1'b0;
    back_space      = 1'b0;
    home            = 1'b0;
    if (state_reg == S_PUT) begin
      col_advance = 1'b1;
    end else if (accept && !is_printable(code)) begin
      case (code)
        ASCII_LF: begin
          carriage_return = 1'b1;
          row_advance     = 1'b1;
        end
        ASCII_CR: carriage_return = 1'b1;
        ASCII_BS: back_space      = 1'b1;
        ASCII_FF: home            = 1'b1;
        default:  ;
      endcase
    end
  end

  // k_reg is the word counter shared by SCROLL, FILL and CLEAR; it is zero
  // on entry to each of them.
  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          if (is_printable(code))
            state_next = S_PUT;
          else if (code == ASCII_FF)
            state_next = S_CLEAR;
          else if (wrap_bottom)
            state_next = S_SCROLL;
        end
      end
      S_PUT: state_next = wrap_bottom ? S_SCROLL : S_IDLE;
      S_SCROLL: begin
        if (k_reg == 10'(SCROLL_WORDS)) begin
          k_next     = 10'd0;
          state_next = S_FILL;
        end else begin
          k_next = k_reg + 10'd1;
        end
      end
      S_FILL: begin
        if (k_reg == 10'(WPR - 1)) begin
          k_next     = 10'd0;
          state_next = S_IDLE;
        end else begin
          k_next = k_reg + 10'd1;
        end
      end
      S_CLEAR: begin
        if (k_reg == 10'(WORDS - 1)) begin
          k_next     = 10'd0;
          state_next = S_IDLE;
        end else begin
          k_next = k_reg + 10'd1;
        end
      end
      default: begin
        state_next = S_IDLE;
        k_next     = 10'd0;
      end
    endcase
  end

  // Single-glyph write: one byte lane selected by the low column bits.
  assign put_addr = 10'(cursor_y) * 10'(WPR) + 10'(cursor_x[6:2]);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign put_be[gi]           = (cursor_x[1:0] == 2'(gi));
      assign put_data[8*gi +: 8]  = (cursor_x[1:0] == 2'(gi)) ? glyph_reg : 8'h00;
    end
  endgenerate

  // VRAM strobes are decoded straight from state so a reset cycle or IDLE
  // can never leak a write. In SCROLL the read for word k+WPR is issued while
  // the word fetched on the previous cycle is written to k-1.
  always_comb begin
    bus.vram_re    = 1'b0;
    bus.vram_raddr = 10'd0;
    bus.vram_we    = 1'b0;
    bus.vram_waddr = 10'd0;
    bus.vram_wdata = 32'd0;
    bus.vram_be    = 4'd0;
    if (!Reset) begin
      case (state_reg)
        S_PUT: begin
          bus.vram_we    = 1'b1;
          bus.vram_waddr = put_addr;
          bus.vram_wdata = put_data;
          bus.vram_be    = put_be;
        end
        S_SCROLL: begin
          if (k_reg < 10'(SCROLL_WORDS)) begin
            bus.vram_re    = 1'b1;
            bus.vram_raddr = k_reg + 10'(WPR);
          end
          if (k_reg != 10'd0) begin
            bus.vram_we    = 1'b1;
            bus.vram_waddr = k_reg - 10'd1;
            bus.vram_wdata = bus.vram_rdata;
            bus.vram_be    = 4'hF;
          end
        end
        S_FILL: begin
          bus.vram_we    = 1'b1;
          bus.vram_waddr = k_reg + 10'(SCROLL_WORDS);
          bus.vram_wdata = {4{BLANK}};
          bus.vram_be    = 4'hF;
        end
        S_CLEAR: begin
          bus.vram_we    = 1'b1;
          bus.vram_waddr = k_reg;
          bus.vram_wdata = {4{BLANK}};
          bus.vram_be    = 4'hF;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      k_reg     <= 10'd0;
      glyph_reg <= 8'd0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      // The glyph is captured at acceptance; char_data may change afterwards.
      if (accept)
        glyph_reg <= bus.char_data;
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
module tb_text_console_writer;
  import console_pkg::*;

  localparam logic [7:0] BLANK_B = 8'h20;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [6:0] cursor_x;
  logic [4:0] cursor_y;
  logic       busy;

  text_console_writer_if bus();

  text_console_writer #(
    .COLS(COLS), .ROWS(ROWS), .BLANK(BLANK_B), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .bus      (bus),
    .cursor_x (cursor_x),
    .cursor_y (cursor_y),
    .busy     (busy)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  wr_t         exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          tx_n = 0;
  logic [7:0]  screen [0:COLS*ROWS-1];
  int          mx = 0;
  int          my = 0;
  logic [31:0] mem [0:1023];

  // ---------------- VRAM behavioural memory ----------------
  always @(posedge Clk) begin
    if (bus.vram_we)
      for (int n = 0; n < 4; n++)
        if (bus.vram_be[n]) mem[bus.vram_waddr][8*n +: 8] <= bus.vram_wdata[8*n +: 8];
    if (bus.vram_re) bus.vram_rdata <= mem[bus.vram_raddr];
  end

  // ---------------- write monitor / scoreboard ----------------
  always @(negedge Clk) begin : mon
    wr_t e;
    if (!Reset) begin
      if ((bus.vram_we || bus.vram_re) && !busy) begin
        total++; bad++;
        $display("FAIL idle_strobe: got we=%0b re=%0b while busy=0", bus.vram_we, bus.vram_re);
      end
      if (bus.vram_re && bus.vram_raddr >= 10'(VRAM_WORDS)) begin
        total++; bad++;
        $display("FAIL raddr_range: got %0d want < %0d", bus.vram_raddr, VRAM_WORDS);
      end
      if (bus.vram_we && bus.vram_waddr >= 10'(VRAM_WORDS)) begin
        total++; bad++;
        $display("FAIL waddr_range: got %0d want < %0d", bus.vram_waddr, VRAM_WORDS);
      end
      if (bus.vram_we) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: got addr=%0d data=%08h be=%b want none",
                   bus.vram_waddr, bus.vram_wdata, bus.vram_be);
        end else begin
          e = exp_q.pop_front();
          if (bus.vram_waddr !== e.addr || bus.vram_wdata !== e.data || bus.vram_be !== e.be) begin
            bad++;
            $display("FAIL vram_write: got addr=%0d data=%08h be=%b want addr=%0d data=%08h be=%b",
                     bus.vram_waddr, bus.vram_wdata, bus.vram_be, e.addr, e.data, e.be);
          end
        end
      end
    end
  end

  task automatic check(input string name, input longint got, input longint want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
    end
  endtask

  // ---------------- reference model (screen of bytes) ----------------
  function automatic logic [31:0] word_of(input int w);
    return {screen[4*w+3], screen[4*w+2], screen[4*w+1], screen[4*w]};
  endfunction

  task automatic push_full_image();
    for (int w = 0; w < VRAM_WORDS; w++)
      exp_q.push_back(wr_t'{addr: 10'(w), data: word_of(w), be: 4'hF});
  endtask

  task automatic model_clear();
    for (int i = 0; i < COLS*ROWS; i++) screen[i] = BLANK_B;
    mx = 0; my = 0;
    push_full_image();
  endtask

  task automatic model_row_adv(output bit scrolled);
    scrolled = 1'b0;
    if (my < ROWS-1) my++;
    else begin
      for (int i = 0; i < COLS*(ROWS-1); i++) screen[i] = screen[i+COLS];
      for (int i = COLS*(ROWS-1); i < COLS*ROWS; i++) screen[i] = BLANK_B;
      push_full_image();
      scrolled = 1'b1;
    end
  endtask

  // Updates the model for one accepted glyph; returns cycles until ready again.
  task automatic model_accept(input logic [7:0] c, output int lat);
    logic [6:0] code;
    bit sc;
    int lane;
    code = c[6:0];
    sc = 1'b0;
    lat = 1;
    if (code >= 7'h20 && code <= 7'h7E) begin
      lane = mx % 4;
      exp_q.push_back(wr_t'{addr: 10'(my*WORDS_PER_ROW + mx/4),
                            data: 32'(c) << (8*lane), be: 4'(1 << lane)});
      screen[my*COLS + mx] = c;
      if (mx < COLS-1) mx++;
      else begin mx = 0; model_row_adv(sc); end
      lat = sc ? 603 : 2;
    end else if (code == ASCII_LF) begin
      mx = 0; model_row_adv(sc);
      lat = sc ? 602 : 1;
    end else if (code == ASCII_CR) mx = 0;
    else if (code == ASCII_BS) begin if (mx > 0) mx--; end
    else if (code == ASCII_FF) begin model_clear(); lat = 601; end
  endtask

  // ---------------- stimulus helpers ----------------
  // Called at a negedge; counts the current cycle as 1.
  task automatic wait_ready(output int lat);
    lat = 1;
    while (!bus.char_ready && lat < 3000) begin
      @(negedge Clk);
      lat++;
    end
  endtask

  task automatic send(input logic [7:0] c);
    int exp_lat, lat, guard;
    guard = 0;
    while (!bus.char_ready && guard < 3000) begin @(negedge Clk); guard++; end
    bus.char_valid = 1'b1;
    bus.char_data  = c;
    model_accept(c, exp_lat);
    @(posedge Clk); #1;
    bus.char_valid = 1'b0;
    bus.char_data  = 8'($urandom);
    @(negedge Clk);
    wait_ready(lat);
    tx_n++;
    $display("tx %0d: char=0x%02h cursor=(%0d,%0d) latency=%0d", tx_n, c, cursor_x, cursor_y, lat);
    check("latency", lat, exp_lat);
    check("cursor_x", cursor_x, mx);
    check("cursor_y", cursor_y, my);
    check("busy_at_ready", busy, 0);
  endtask

  function automatic logic [7:0] rand_printable();
    logic [7:0] v;
    v[7]   = 1'($urandom_range(0, 1));
    v[6:0] = 7'($urandom_range(32, 126));
    return v;
  endfunction

  function automatic logic [7:0] rand_code();
    logic [7:0] v;
    int r;
    r = $urandom_range(0, 31);
    v = rand_printable();
    case (r)
      0, 1: v[6:0] = ASCII_LF;
      2:    v[6:0] = ASCII_CR;
      3, 4: v[6:0] = ASCII_BS;
      5:    v[6:0] = ASCII_FF;
      6:    v[6:0] = 7'h07;
      7:    v[6:0] = 7'h7F;
      8:    v[6:0] = 7'h00;
      default: ;
    endcase
    return v;
  endfunction

  // Asserts reset, checks the reset values, then checks the automatic clear.
  task automatic reset_and_clear();
    int lat;
    @(posedge Clk); #1;
    Reset = 1'b1;
    bus.char_valid = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    check("rst_next_we", bus.vram_we, 0);
    check("rst_next_re", bus.vram_re, 0);
    check("rst_next_cursor", {cursor_y, cursor_x}, 0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("rst_char_ready", bus.char_ready, 0);
    check("rst_raddr", bus.vram_raddr, 0);
    check("rst_waddr", bus.vram_waddr, 0);
    check("rst_wdata", bus.vram_wdata, 0);
    check("rst_be", bus.vram_be, 0);
    check("rst_busy", busy, 0);
    check("rst_cursor_x", cursor_x, 0);
    check("rst_cursor_y", cursor_y, 0);
    exp_q.delete();
    model_clear();
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(negedge Clk);
    check("clear_busy_first", busy, 1);
    check("clear_we_first", bus.vram_we, 1);
    check("clear_waddr_first", bus.vram_waddr, 0);
    wait_ready(lat);
    $display("tx reset: clear finished, ready after %0d cycles", lat);
    check("clear_latency", lat, 601);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int lat_dummy, mism;
    bus.char_valid = 1'b0;
    bus.char_data  = 8'h00;
    bus.vram_rdata = 32'h0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[CTRL_REG_ADDR] = 32'hC0DE_5A5A;

    reset_and_clear();

    // Two glyphs in word 0, lanes 0 and 1 (second with invert bit).
    send(8'h41);
    send(8'hC2);

    // Right-most column of row 5.
    send(8'h0D);
    repeat (5) send(8'h0A);
    repeat (COLS-1) send(rand_printable());
    send(8'h5A);

    // Fill some rows, reach the last row, then LF scrolls.
    while (my < ROWS-1) begin
      repeat ($urandom_range(0, 6)) send(rand_printable());
      send(8'h0A);
    end
    send(8'h0A);

    // BS / CR / BEL at column 0: no writes, back-to-back acceptance.
    send(8'h08);
    send(8'h0D);
    send(8'h07);

    // Printable at bottom-right corner: PUT then scroll and fill.
    repeat (COLS-1) send(rand_printable());
    send(rand_printable());

    // Randomised traffic.
    repeat (200) send(rand_code());

    // Reset in the middle of a scroll.
    while (my < ROWS-1) send(8'h0A);
    bus.char_valid = 1'b1;
    bus.char_data  = 8'h0A;
    model_accept(8'h0A, lat_dummy);
    @(posedge Clk); #1;
    bus.char_valid = 1'b0;
    repeat (99) @(posedge Clk);
    @(negedge Clk);
    check("mid_scroll_busy", busy, 1);
    reset_and_clear();
    send(8'h4F);

    // Final image and bookkeeping.
    repeat (3) @(negedge Clk);
    check("pending_writes", exp_q.size(), 0);
    mism = 0;
    for (int w = 0; w < VRAM_WORDS; w++)
      if (mem[w] !== word_of(w)) mism++;
    check("vram_image_mismatches", mism, 0);
    check("ctrl_reg_untouched", mem[CTRL_REG_ADDR], 32'hC0DE_5A5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/text_console_writer.md
# text_console_writer

Writer-side companion of the text-mode colour mapper. Consumes a stream of 8-bit glyph codes (bit 7 = per-glyph invert, bits 6:0 = ASCII) and writes them into the 600-word text VRAM with the same packing the pixel path reads: 80×30 glyphs, 4 glyphs per 32-bit word, 20 words per row. It keeps a cursor and handles control characters, clear-screen and one-row hardware scroll. It never writes word 600, which is the colour control register.

## Interface
Parameters:
- COLS, 80, glyph columns; must be a multiple of 4
- ROWS, 30, glyph rows
- BLANK, 8'h20, fill byte for clear and scroll
- CLEAR_ON_RESET, 1, when 1, a full clear runs immediately after reset

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high
- char_valid  in  1  glyph code offered
- char_data  in  8  glyph code (bit 7 invert, bits 6:0 ASCII)
- char_ready  out  1  block accepts char_data this cycle
- vram_re  out  1  VRAM read strobe
- vram_raddr  out  10  VRAM read word address
- vram_rdata  in  32  VRAM read data, valid 1 cycle after vram_re
- vram_we  out  1  VRAM write strobe
- vram_waddr  out  10  VRAM write word address
- vram_wdata  out  32  VRAM write data
- vram_be  out  4  byte enables; lane n = bits 8n+7:8n
- cursor_x  out  7  current column, 0..COLS-1
- cursor_y  out  5  current row, 0..ROWS-1
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, PUT, SCROLL, FILL, CLEAR.
- char_ready equals (state==IDLE) and not Reset. A glyph is accepted on a cycle where char_valid and char_ready are both high.
- Classification uses char_data[6:0]:
  - 0x20..0x7E: printable. Move to PUT. In PUT, issue one write: waddr = y*(COLS/4) + x/4; be = one-hot on lane x%4; wdata = char_data placed in that lane, other lanes 0. Then advance the cursor.
  - 0x0A LF: x=0, then advance the row.
  - 0x0D CR: x=0.
  - 0x08 BS: x=x-1 when x>0; no erase.
  - 0x0C FF: enter CLEAR; cursor 0,0.
  - All other codes: consumed with no effect.
- Column advance: if x<COLS-1, x++. Otherwise x=0 and advance the row.
- Row advance: if y<ROWS-1, y++. Otherwise enter SCROLL and y stays ROWS-1.
- SCROLL uses counter k = 0..580:
  - For k<580: vram_re=1, raddr=k+20.
  - For k≥1: vram_we=1, waddr=k-1, wdata=vram_rdata, be=4'hF.
  - After k=580, go to FILL.
- FILL writes words 580..599 with {4{BLANK}}, be=4'hF, then returns to IDLE.
- CLEAR writes words 0..599 with {4{BLANK}}, be=4'hF, then returns to IDLE.
- Addresses never exceed 599; vram_re and vram_we are never asserted in IDLE.

## Timing
- Reset values: char_ready=0, vram_re=0, vram_we=0, vram_raddr=0, vram_waddr=0, vram_wdata=0, vram_be=0, cursor 0,0, busy=0.
- With CLEAR_ON_RESET=1, state is CLEAR on the first cycle after Reset deasserts, and busy=1.
- Printable glyph accepted at cycle t:
  - Write strobe at t+1.
  - Cursor updated at end of t+1.
  - char_ready high again at t+2, giving one glyph per 2 cycles.
- Non-printable, non-FF glyph: cursor updates at end of t; char_ready stays high, so back-to-back acceptance is allowed.
- Printable glyph at the bottom-right corner: PUT at t+1, then SCROLL 581 cycles, then FILL 20 cycles. char_ready returns at t+603.
- LF on the last row: SCROLL starts at t+1; char_ready returns at t+602.
- CLEAR lasts 600 cycles: 600 writes (1 cycle each, no read latency) on cycles 1..600 after entry. char_ready high on cycle 601.
- SCROLL reads and writes overlap. Write of word k-1 uses data returned from the read issued one cycle earlier.
- Reset mid-operation aborts immediately. Strobes are low on the next cycle and the cursor returns to 0,0. With CLEAR_ON_RESET=1, a fresh clear starts.
- char_valid while busy is ignored, and char_data need not be held stable.

## Structure
- Package console_pkg holds:
  - COLS, ROWS, WORDS_PER_ROW=20, VRAM_WORDS=600, CTRL_REG_ADDR=600
  - ASCII constants: LF, CR, BS, FF
  - The state enum typedef
- Sub-module console_cursor: owns x/y registers and col_advance/row_advance/home/bs inputs. It outputs wrap_bottom, which the top FSM uses to enter SCROLL.

## Test plan
- Reset with CLEAR_ON_RESET=1 -> 600 writes, addr 0..599, wdata 0x20202020, be 4'hF; char_ready rises on cycle 601; word 600 is never written.
- Send 0x41 then 0xC2 from 0,0 -> write addr 0, be 4'b0001, wdata 0x00000041; then addr 0, be 4'b0010, wdata 0x0000C200; cursor_x=2.
- Cursor at x=79, y=5, send 0x5A -> write addr 119, be 4'b1000, wdata 0x5A000000; cursor becomes 0,6.
- Cursor at y=29, send 0x0A -> 580 copies (word i gets prior word i+20), then 20 blank writes at 580..599; cursor 0,29; char_ready low for 601 cycles.
- At x=0, send 0x08, 0x0D, 0x07 -> no VRAM strobes, cursor unchanged, all three accepted on consecutive cycles.
- Assert Reset on cycle 100 of SCROLL -> strobes low the next cycle, cursor 0,0, CLEAR restarts at address 0.
